// File: rtl/irq_edge_arbiter_if.sv
// Interrupt arbiter bus: request/mask inputs, CPU ack/EOI handshake, and
// the presented interrupt plus status back toward the CPU.
interface irq_edge_arbiter_if #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
);
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] mask;
    logic             irq_ack;
    logic             irq_eoi;
    logic             irq;
    logic [ID_W-1:0]  irq_id;
    logic [N_SRC-1:0] pending;
    logic             in_service;

    // Request side / CPU side: drives requests, masks and the handshake.
    modport master (
        output req, mask, irq_ack, irq_eoi,
        input  irq, irq_id, pending, in_service
    );

    // Arbiter side.
    modport slave (
        input  req, mask, irq_ack, irq_eoi,
        output irq, irq_id, pending, in_service
    );
endinterface

// File: rtl/irq_edge_arbiter.sv
// Edge-capturing fixed-priority interrupt arbiter. Each rising edge on a
// request line latches a pending bit; the lowest-index unmasked pending
// source is presented to the CPU and walked through ack and EOI, so only
// one interrupt is ever in flight.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing presented; grant lowest eligible pending source
// REQ   | irq high, irq_id frozen until the CPU acks
// SVC   | handler running (in_service high), waiting for EOI
module irq_edge_arbiter #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    irq_edge_arbiter_if.slave   bus
);

    if (ID_W != $clog2(N_SRC)) begin : g_bad_id_w
        $error("irq_edge_arbiter: ID_W must equal clog2(N_SRC)");
    end
    if (N_SRC < 2 || N_SRC > 16) begin : g_bad_n_src
        $error("irq_edge_arbiter: N_SRC must be in 2..16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] prev_req_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic             irq_q, irq_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic             in_service_q, in_service_d;

    logic [N_SRC-1:0] edge_w;
    logic [N_SRC-1:0] eligible_w;
    logic [N_SRC-1:0] clr_w;
    logic [ID_W-1:0]  winner_w;

    assign edge_w     = bus.req & ~prev_req_q;
    assign eligible_w = pending_q & bus.mask;

    // Fixed priority: scan from the top so the lowest set index wins.
    always_comb begin
        winner_w = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible_w[i]) begin
                winner_w = ID_W'(i);
            end
        end
    end

    // Next-state and registered-output logic for the ack/EOI sequence.
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        clr_w        = '0;
        unique case (state_q)
            IDLE: begin
                irq_d        = 1'b0;
                in_service_d = 1'b0;
                if (eligible_w != '0) begin
                    irq_id_d = winner_w;
                    irq_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // No re-arbitration here: the CPU may already be reading irq_id.
                irq_d = 1'b1;
                if (bus.irq_ack) begin
                    clr_w[irq_id_q] = 1'b1;
                    irq_d           = 1'b0;
                    in_service_d    = 1'b1;
                    state_d         = SVC;
                end
            end
            SVC: begin
                irq_d        = 1'b0;
                in_service_d = 1'b1;
                if (bus.irq_eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                irq_d        = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // A new edge wins over the ack clear so a re-trigger is never lost.
    always_comb begin
        pending_d = (pending_q & ~clr_w) | edge_w;
    end

    // State, edge history, pending set and outputs; async reset drops everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_req_q   <= '0;
            pending_q    <= '0;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_req_q   <= bus.req;
            pending_q    <= pending_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_irq_edge_arbiter.sv
// Bench for irq_edge_arbiter: table of per-cycle vectors plus a hand-built
// async-reset sequence; expectations go through a scoreboard queue.
module tb_irq_edge_arbiter;

    logic clk;
    logic rst;

    irq_edge_arbiter_if #(.N_SRC(4), .ID_W(2)) bus ();

    irq_edge_arbiter #(.N_SRC(4), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic       ack;
        logic       eoi;
        logic       e_irq;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        logic       e_svc;
        string      name;
    } vec_t;

    typedef struct {
        logic       irq;
        logic [1:0] id;
        logic [3:0] pend;
        logic       svc;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total;
    int   bad;

    task automatic add(input logic [3:0] req, input logic [3:0] mask,
                       input logic ack, input logic eoi,
                       input logic e_irq, input logic [1:0] e_id,
                       input logic [3:0] e_pend, input logic e_svc,
                       input string name);
        vec_t v;
        v.req = req; v.mask = mask; v.ack = ack; v.eoi = eoi;
        v.e_irq = e_irq; v.e_id = e_id; v.e_pend = e_pend; v.e_svc = e_svc;
        v.name = name;
        tbl.push_back(v);
    endtask

    task automatic push_exp(input logic irq, input logic [1:0] id,
                            input logic [3:0] pend, input logic svc,
                            input string name);
        exp_t e;
        e.irq = irq; e.id = id; e.pend = pend; e.svc = svc; e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=0 entries required=1");
            return;
        end
        e = sb.pop_front();
        total++;
        if (bus.irq !== e.irq) begin
            bad++;
            $display("FAIL %s.irq actual=%0b required=%0b", e.name, bus.irq, e.irq);
        end
        total++;
        if (bus.irq_id !== e.id) begin
            bad++;
            $display("FAIL %s.irq_id actual=%0d required=%0d", e.name, bus.irq_id, e.id);
        end
        total++;
        if (bus.pending !== e.pend) begin
            bad++;
            $display("FAIL %s.pending actual=%b required=%b", e.name, bus.pending, e.pend);
        end
        total++;
        if (bus.in_service !== e.svc) begin
            bad++;
            $display("FAIL %s.in_service actual=%0b required=%0b", e.name, bus.in_service, e.svc);
        end
    endtask

    // Called at a negedge: drive inputs, queue the expectation, clock, compare.
    task automatic apply(input vec_t v);
        bus.req     = v.req;
        bus.mask    = v.mask;
        bus.irq_ack = v.ack;
        bus.irq_eoi = v.eoi;
        push_exp(v.e_irq, v.e_id, v.e_pend, v.e_svc, v.name);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        apply(v);
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;
        rst         = 1'b1;
        bus.req     = '0;
        bus.mask    = 4'hF;
        bus.irq_ack = 1'b0;
        bus.irq_eoi = 1'b0;

        //   req     mask    ack eoi  irq id  pend    svc
        // single source
        add(4'b0000, 4'hF, 0, 0,   0, 0, 4'b0000, 0, "s_idle");
        add(4'b0100, 4'hF, 0, 0,   0, 0, 4'b0100, 0, "s_capture");
        add(4'b0100, 4'hF, 0, 0,   1, 2, 4'b0100, 0, "s_present");
        add(4'b0100, 4'hF, 0, 0,   1, 2, 4'b0100, 0, "s_hold");
        add(4'b0000, 4'hF, 1, 0,   0, 2, 4'b0000, 1, "s_ack");
        add(4'b0000, 4'hF, 0, 0,   0, 2, 4'b0000, 1, "s_svc");
        add(4'b0000, 4'hF, 1, 0,   0, 2, 4'b0000, 1, "s_ack_in_svc");
        add(4'b0000, 4'hF, 0, 1,   0, 2, 4'b0000, 0, "s_eoi");
        add(4'b0000, 4'hF, 0, 0,   0, 2, 4'b0000, 0, "s_quiet");
        // priority 3 vs 1
        add(4'b1010, 4'hF, 0, 0,   0, 2, 4'b1010, 0, "p_capture");
        add(4'b1010, 4'hF, 0, 0,   1, 1, 4'b1010, 0, "p_first1");
        add(4'b1010, 4'hF, 1, 0,   0, 1, 4'b1000, 1, "p_ack1");
        add(4'b0000, 4'hF, 0, 1,   0, 1, 4'b1000, 0, "p_eoi1");
        add(4'b0000, 4'hF, 0, 0,   1, 3, 4'b1000, 0, "p_then3");
        add(4'b0000, 4'hF, 1, 0,   0, 3, 4'b0000, 1, "p_ack3");
        add(4'b0000, 4'hF, 0, 1,   0, 3, 4'b0000, 0, "p_eoi3");
        // hold in REQ against a higher-priority arrival
        add(4'b1000, 4'hF, 0, 0,   0, 3, 4'b1000, 0, "h_capture3");
        add(4'b1000, 4'hF, 0, 0,   1, 3, 4'b1000, 0, "h_present3");
        add(4'b1001, 4'hF, 0, 0,   1, 3, 4'b1001, 0, "h_src0_arrives");
        add(4'b1001, 4'hF, 0, 0,   1, 3, 4'b1001, 0, "h_still3");
        add(4'b1001, 4'hF, 0, 1,   1, 3, 4'b1001, 0, "h_eoi_in_req");
        add(4'b0000, 4'hF, 1, 0,   0, 3, 4'b0001, 1, "h_ack3");
        add(4'b0000, 4'hF, 0, 1,   0, 3, 4'b0001, 0, "h_eoi3");
        add(4'b0000, 4'hF, 0, 0,   1, 0, 4'b0001, 0, "h_present0");
        add(4'b0000, 4'hF, 1, 0,   0, 0, 4'b0000, 1, "h_ack0");
        add(4'b0000, 4'hF, 0, 1,   0, 0, 4'b0000, 0, "h_eoi0");
        // mask
        add(4'b0001, 4'hE, 0, 0,   0, 0, 4'b0001, 0, "m_capture_masked");
        add(4'b0001, 4'hE, 0, 0,   0, 0, 4'b0001, 0, "m_blocked1");
        add(4'b0001, 4'hE, 0, 0,   0, 0, 4'b0001, 0, "m_blocked2");
        add(4'b0001, 4'hF, 0, 0,   1, 0, 4'b0001, 0, "m_unmask");
        add(4'b0000, 4'hF, 1, 0,   0, 0, 4'b0000, 1, "m_ack");
        add(4'b0000, 4'hF, 0, 1,   0, 0, 4'b0000, 0, "m_eoi");
        add(4'b0100, 4'hF, 0, 0,   0, 0, 4'b0100, 0, "m2_capture");
        add(4'b0000, 4'hF, 0, 0,   1, 2, 4'b0100, 0, "m2_present");
        add(4'b0000, 4'h0, 0, 0,   1, 2, 4'b0100, 0, "m2_masked_in_req");
        add(4'b0000, 4'h0, 1, 0,   0, 2, 4'b0000, 1, "m2_ack");
        add(4'b0000, 4'hF, 0, 1,   0, 2, 4'b0000, 0, "m2_eoi");
        // set/clear collision and level hold
        add(4'b0100, 4'hF, 0, 0,   0, 2, 4'b0100, 0, "c_capture");
        add(4'b0000, 4'hF, 0, 0,   1, 2, 4'b0100, 0, "c_present");
        add(4'b0100, 4'hF, 1, 0,   0, 2, 4'b0100, 1, "c_ack_reedge");
        add(4'b0100, 4'hF, 0, 0,   0, 2, 4'b0100, 1, "c_svc");
        add(4'b0100, 4'hF, 0, 1,   0, 2, 4'b0100, 0, "c_eoi");
        add(4'b0100, 4'hF, 0, 0,   1, 2, 4'b0100, 0, "c_reserve");
        add(4'b0100, 4'hF, 1, 0,   0, 2, 4'b0000, 1, "c_ack2");
        add(4'b0100, 4'hF, 0, 1,   0, 2, 4'b0000, 0, "c_eoi2");
        add(4'b0100, 4'hF, 0, 0,   0, 2, 4'b0000, 0, "c_level_hold1");
        add(4'b0100, 4'hF, 0, 0,   0, 2, 4'b0000, 0, "c_level_hold2");
        add(4'b0000, 4'hF, 0, 0,   0, 2, 4'b0000, 0, "c_drop");
        // lead-in to async reset: SVC on id 0 with pending 1010
        add(4'b0001, 4'hF, 0, 0,   0, 2, 4'b0001, 0, "r_capture0");
        add(4'b1010, 4'hF, 0, 0,   1, 0, 4'b1011, 0, "r_present0");
        add(4'b1010, 4'hF, 1, 0,   0, 0, 4'b1010, 1, "r_svc0");

        #12;
        push_exp(1'b0, 2'd0, 4'b0000, 1'b0, "reset_state");
        check_pop();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Async reset mid-cycle, away from any clock edge.
        #3;
        rst = 1'b1;
        #1;
        push_exp(1'b0, 2'd0, 4'b0000, 1'b0, "async_reset_now");
        check_pop();
        @(posedge clk);
        #1;
        push_exp(1'b0, 2'd0, 4'b0000, 1'b0, "reset_held");
        check_pop();

        // Release with req 1010 still high: each counts as one fresh edge.
        @(negedge clk);
        rst = 1'b0;
        v.req = 4'b1010; v.mask = 4'hF; v.ack = 0; v.eoi = 0;
        v.e_irq = 0; v.e_id = 0; v.e_pend = 4'b1010; v.e_svc = 0; v.name = "rr_capture";
        apply(v);
        v.e_irq = 1; v.e_id = 1; v.e_pend = 4'b1010; v.e_svc = 0; v.name = "rr_present1";
        step(v);
        v.ack = 1;
        v.e_irq = 0; v.e_id = 1; v.e_pend = 4'b1000; v.e_svc = 1; v.name = "rr_ack1";
        step(v);
        v.ack = 0; v.eoi = 1;
        v.e_irq = 0; v.e_id = 1; v.e_pend = 4'b1000; v.e_svc = 0; v.name = "rr_eoi1";
        step(v);
        v.eoi = 0;
        v.e_irq = 1; v.e_id = 3; v.e_pend = 4'b1000; v.e_svc = 0; v.name = "rr_present3";
        step(v);
        v.ack = 1;
        v.e_irq = 0; v.e_id = 3; v.e_pend = 4'b0000; v.e_svc = 1; v.name = "rr_ack3";
        step(v);
        v.ack = 0; v.eoi = 1;
        v.e_irq = 0; v.e_id = 3; v.e_pend = 4'b0000; v.e_svc = 0; v.name = "rr_eoi3";
        step(v);
        v.eoi = 0;
        v.e_irq = 0; v.e_id = 3; v.e_pend = 4'b0000; v.e_svc = 0; v.name = "rr_no_more";
        step(v);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover actual=%0d entries required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
